// File: rtl/alu_exec_unit.sv
// alu_exec_unit -- single-issue RV32-style integer ALU with valid/ready handshakes.
//
// Purpose:
//   Accepts one operation per handshake, latches the operands, and returns a
//   result through a valid/ready output port. Non-shift operations (and shifts by
//   zero) complete one cycle after acceptance. Shifts by a non-zero amount are
//   performed serially, one bit per cycle, so no barrel shifter is built.
//
// Ports:
//   clk       - sole clock, all state updates on the rising edge
//   rst_n     - synchronous active-low reset
//   in_valid  - request valid
//   in_ready  - unit can accept a request this cycle
//   alu_ctrl  - 4-bit operation code
//   op_a      - operand A (rs1)
//   op_b      - operand B (rs2 or immediate); shift amount is op_b[4:0]
//   out_valid - result valid
//   out_ready - consumer accepts result
//   result    - operation result
//   zero      - high when result == 0
//   illegal   - high with out_valid when alu_ctrl was unsupported
module alu_exec_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SLL  = 4'd1;
  localparam logic [3:0] OP_SLT  = 4'd2;
  localparam logic [3:0] OP_SLTU = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SRL  = 4'd5;
  localparam logic [3:0] OP_OR   = 4'd6;
  localparam logic [3:0] OP_AND  = 4'd7;
  localparam logic [3:0] OP_SUB  = 4'd8;
  localparam logic [3:0] OP_SRA  = 4'd9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [3:0]      ctrl_q, ctrl_d;
  logic [XLEN-1:0] res_q, res_d;
  logic            illegal_q, illegal_d;
  logic            valid_q, valid_d;

  logic [4:0]      shamt;
  logic            is_shift;
  logic            accept;
  logic [XLEN-1:0] calc_res;
  logic            calc_ill;

  // Single-cycle datapath for the live request. Shift codes only reach this
  // path when shamt == 0, so their result is simply op_a.
  always_comb begin
    shamt    = op_b[4:0];
    is_shift = (alu_ctrl == OP_SLL) || (alu_ctrl == OP_SRL) || (alu_ctrl == OP_SRA);
    calc_res = '0;
    calc_ill = 1'b0;
    case (alu_ctrl)
      OP_ADD:  calc_res = op_a + op_b;
      OP_SUB:  calc_res = op_a - op_b;
      OP_SLT:  calc_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      OP_SLTU: calc_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      OP_XOR:  calc_res = op_a ^ op_b;
      OP_OR:   calc_res = op_a | op_b;
      OP_AND:  calc_res = op_a & op_b;
      OP_SLL, OP_SRL, OP_SRA: calc_res = op_a;
      default: calc_ill = 1'b1;
    endcase
  end

  // A finished result may be replaced in the same cycle it is consumed,
  // which is what removes the bubble between back-to-back operations.
  always_comb begin
    in_ready  = rst_n && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
    accept    = in_valid && in_ready;
    state_d   = state_q;
    cnt_d     = cnt_q;
    ctrl_d    = ctrl_q;
    res_d     = res_q;
    illegal_d = illegal_q;
    valid_d   = valid_q;
    case (state_q)
      IDLE, DONE: begin
        if ((state_q == DONE) && out_ready) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
        if (accept) begin
          ctrl_d = alu_ctrl;
          if (is_shift && (shamt != 5'd0)) begin
            state_d   = SHIFT;
            res_d     = op_a;
            cnt_d     = shamt;
            illegal_d = 1'b0;
            valid_d   = 1'b0;
          end else begin
            state_d   = DONE;
            res_d     = calc_res;
            cnt_d     = 5'd0;
            illegal_d = calc_ill;
            valid_d   = 1'b1;
          end
        end
      end
      SHIFT: begin
        case (ctrl_q)
          OP_SLL:  res_d = {res_q[XLEN-2:0], 1'b0};
          OP_SRA:  res_d = {res_q[XLEN-1], res_q[XLEN-1:1]};
          default: res_d = {1'b0, res_q[XLEN-1:1]};
        endcase
        cnt_d = cnt_q - 5'd1;
        // The last single-bit step happens this cycle, so the result is valid next.
        if (cnt_q == 5'd1) begin
          state_d = DONE;
          valid_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 5'd0;
      ctrl_q    <= 4'd0;
      res_q     <= '0;
      illegal_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ctrl_q    <= ctrl_d;
      res_q     <= res_d;
      illegal_q <= illegal_d;
      valid_q   <= valid_d;
    end
  end

  assign out_valid = valid_q;
  assign result    = res_q;
  assign illegal   = illegal_q;
  assign zero      = (res_q == '0);

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit -- scoreboard bench for alu_exec_unit.
// A driver issues directed and random requests and pushes the reference
// model's expected response (value and completion cycle) into a queue; a
// monitor pops and compares whenever the DUT presents a result.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_ctrl;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  alu_exec_unit #(.XLEN(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_ctrl  (alu_ctrl),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic        zero;
    logic        ill;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   ready_rand = 1'b0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference model: the architectural meaning of each opcode.
  function automatic exp_t model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   sh;
    int   lat;
    sh    = int'(b % 32);
    lat   = 1;
    e.ill = 1'b0;
    case (c)
      4'd0: e.res = a + b;
      4'd8: e.res = a - b;
      4'd1: begin e.res = a << sh; lat = 1 + sh; end
      4'd2: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd3: e.res = (a < b) ? 32'd1 : 32'd0;
      4'd4: e.res = a ^ b;
      4'd5: begin e.res = a >> sh; lat = 1 + sh; end
      4'd9: begin e.res = 32'($signed(a) >>> sh); lat = 1 + sh; end
      4'd6: e.res = a | b;
      4'd7: e.res = a & b;
      default: begin e.res = 32'd0; e.ill = 1'b1; end
    endcase
    e.zero = (e.res == 32'd0);
    e.cyc  = lat;
    return e;
  endfunction

  // Call only just after a rising edge. Accept is observed on the falling edge
  // before the capturing rising edge; result is due lat cycles after that edge.
  task automatic send(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   waited;
    bit   got;
    alu_ctrl = c;
    op_a     = a;
    op_b     = b;
    in_valid = 1'b1;
    waited   = 0;
    got      = 1'b0;
    while (!got && waited < 200) begin
      @(negedge clk);
      if (in_ready) got = 1'b1;
      else waited++;
    end
    if (!got) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, required 1", waited);
    end else begin
      e     = model(c, a, b);
      e.cyc = cyc + e.cyc;
      sb.push_back(e);
      $display("[TB] issue ctrl=%0d a=%08h b=%08h exp=%08h ill=%0d due=%0d", c, a, b, e.res, e.ill, e.cyc);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op_a     = $urandom;
    op_b     = $urandom;
    alu_ctrl = 4'($urandom);
  endtask

  // Random backpressure when enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (ready_rand) out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor
  initial begin
    exp_t        e;
    bit          new_item = 1'b1;
    bit          hold = 1'b0;
    logic [31:0] h_res;
    logic        h_zero;
    logic        h_ill;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb.delete();
        new_item = 1'b1;
        hold     = 1'b0;
      end else begin
        if (hold) begin
          chk("hold_valid", 64'(out_valid), 64'd1);
          chk("hold_result", 64'(result), 64'(h_res));
          chk("hold_flags", {62'd0, zero, illegal}, {62'd0, h_zero, h_ill});
        end
        hold = 1'b0;
        if (out_valid) begin
          if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL spurious_out: out_valid=1 result=%08h with nothing outstanding", result);
          end else begin
            e = sb[0];
            if (new_item) begin
              chk("latency", 64'(cyc), 64'(e.cyc));
              new_item = 1'b0;
            end
            if (out_ready) begin
              chk("result", 64'(result), 64'(e.res));
              chk("zero", 64'(zero), 64'(e.zero));
              chk("illegal", 64'(illegal), 64'(e.ill));
              $display("[TB] done result=%08h zero=%0d ill=%0d cycle=%0d", result, zero, illegal, cyc);
              void'(sb.pop_front());
              new_item = 1'b1;
            end else begin
              hold   = 1'b1;
              h_res  = result;
              h_zero = zero;
              h_ill  = illegal;
            end
          end
        end
      end
    end
  end

  initial begin
    int w;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    alu_ctrl  = 4'd0;
    op_a      = 32'd0;
    op_b      = 32'd0;
    out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_zero", 64'(zero), 64'd1);
    chk("rst_illegal", 64'(illegal), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Directed corner cases
    send(4'd0, 32'h7FFF_FFFF, 32'd1);
    send(4'd8, 32'd5, 32'd5);
    send(4'd2, 32'hFFFF_FFFF, 32'd1);
    send(4'd3, 32'hFFFF_FFFF, 32'd1);
    send(4'hF, 32'h1234_5678, 32'h9ABC_DEF0);
    send(4'd1, 32'hDEAD_BEEF, 32'h0000_0020);

    // SRA by 4 with ignored requests during the shift
    send(4'd9, 32'h8000_0000, 32'h0000_0024);
    repeat (3) begin
      in_valid = 1'b1;
      alu_ctrl = 4'd0;
      op_a     = $urandom;
      op_b     = $urandom;
      @(negedge clk);
      chk("shift_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // AND held under backpressure, then ADD accepted in the consuming cycle
    out_ready = 1'b0;
    send(4'd7, 32'hF0F0_00FF, 32'h0FF0_F0F0);
    fork
      send(4'd0, 32'd100, 32'd23);
      begin
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    repeat (3) @(posedge clk);
    #1;

    // Reset in the middle of a long shift
    send(4'd1, 32'h0000_0001, 32'd31);
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_result", 64'(result), 64'd0);
    chk("midrst_in_ready_up", 64'(in_ready), 64'd1);
    repeat (40) @(posedge clk);
    #1;

    // Random traffic with random backpressure
    ready_rand = 1'b1;
    for (int i = 0; i < 300; i++) begin
      logic [31:0] b;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) b[4:0] = 5'd0;
      send(4'($urandom), $urandom, b);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    // Drain
    ready_rand = 1'b0;
    #1;
    out_ready = 1'b1;
    w = 0;
    while (sb.size() != 0 && w < 200) begin
      @(posedge clk);
      w++;
    end
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
    end
    repeat (5) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width.
REQ-002 SHALL have clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have in_valid  input  1  operation request valid.
REQ-005 SHALL have in_ready  output  1  unit can accept a request this cycle.
REQ-006 SHALL have alu_ctrl  input  4  operation code from the ALU control stage.
REQ-007 SHALL have op_a  input  XLEN  operand A (rs1).
REQ-008 SHALL have op_b  input  XLEN  operand B (rs2 or immediate).
REQ-009 SHALL have out_valid  output  1  result valid.
REQ-010 SHALL have out_ready  input  1  consumer accepts result.
REQ-011 SHALL have result  output  XLEN  operation result.
REQ-012 SHALL have zero  output  1  high when result == 0.
REQ-013 SHALL have illegal  output  1  high with out_valid when alu_ctrl was unsupported.

Function
REQ-014 SHALL decode alu_ctrl: 0 ADD, 8 SUB, 1 SLL, 2 SLT (signed), 3 SLTU, 4 XOR, 5 SRL, 9 SRA, 6 OR, 7 AND; any other code -> result 0, illegal=1.
REQ-015 SHALL compute ADD/SUB modulo 2^XLEN, carry/borrow discarded; SLT/SLTU result is 0 or 1 zero-extended.
REQ-016 SHALL use shamt = op_b[4:0] for shifts; op_b[XLEN-1:5] ignored; SRA replicates op_a[XLEN-1].
REQ-017 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-018 SHALL assert in_ready only in IDLE, or in DONE in the same cycle out_ready is high.
REQ-019 SHALL capture request on in_valid && in_ready (handshake cycle N); operands latched, later input changes ignored.
REQ-020 SHALL, for non-shift ops or shifts with shamt=0, go to DONE with out_valid=1 in cycle N+1.
REQ-021 SHALL, for shifts with shamt>0, enter SHIFT, shift by exactly 1 bit per cycle using a 5-bit down-counter loaded with shamt, and assert out_valid in cycle N+1+shamt.
REQ-022 SHALL hold result, zero, illegal and out_valid stable in DONE until out_valid && out_ready.
REQ-023 SHALL, on DONE handshake without a new accept, return to IDLE next cycle with out_valid=0.
REQ-024 SHALL, on DONE handshake coinciding with a new accept, process the new request with no bubble (non-shift result valid next cycle).
REQ-025 SHALL ignore in_valid while in SHIFT (in_ready=0); no request lost or duplicated.
REQ-026 SHALL derive zero and illegal from the registered result/op, never from live inputs.

Reset
REQ-027 SHALL, when rst_n=0 at a rising edge, enter IDLE, clear counter, result=0, out_valid=0, illegal=0; zero=1.
REQ-028 SHALL abort any in-flight op (SHIFT or DONE) on reset; no out_valid issued for it afterward.
REQ-029 SHALL hold in_ready=0 while rst_n=0 and assert it the first cycle after rst_n rises.

Verification
REQ-030 SHALL cover: ADD op_a=0x7FFFFFFF, op_b=1, out_ready=1 -> cycle N+1 result=0x80000000, zero=0.
REQ-031 SHALL cover: SUB op_a=5, op_b=5 -> result=0, zero=1; SLT op_a=0xFFFFFFFF, op_b=1 -> 1; SLTU same operands -> 0.
REQ-032 SHALL cover: SRA op_a=0x80000000, op_b=0x00000024 (shamt 4) -> out_valid at N+5, result=0xF8000000; in_valid pulses during SHIFT ignored.
REQ-033 SHALL cover: AND result held with out_ready=0 for 3 cycles -> result/out_valid stable; then out_ready=1 with new ADD accepted same cycle -> ADD result next cycle.
REQ-034 SHALL cover: alu_ctrl=4'hF -> result=0, illegal=1, zero=1, one cycle latency.
REQ-035 SHALL cover: rst_n=0 mid-SHIFT (SLL shamt 31, cycle 10) -> next cycle IDLE, out_valid=0, result=0; no stale completion.
